// File: rtl/traffic_phase_controller.sv
// Round-robin phase sequencer: GREEN (min/max) -> YELLOW -> ALLRED, idling all-red without demand.
// All outputs are registered one edge after the sensors are sampled; there is no backpressure, and sensors are level-sampled.
module traffic_phase_controller #(
    parameter int NLIGHT    = 5,
    parameter int NPHASE    = 5,
    parameter logic [NPHASE*NLIGHT-1:0] PHASE_MASK =
        {5'b01010, 5'b00101, 5'b00011, 5'b01100, 5'b10000},
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NLIGHT-1:0]           sensor,
    output logic [NLIGHT-1:0][1:0]      light,
    output logic [$clog2(NPHASE)-1:0]   active_phase,
    output logic                        phase_busy
);
    localparam int PW = $clog2(NPHASE);
    localparam int CW = $clog2(MAX_GREEN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;

    // Phase 0 is the leftmost entry of the concatenated table.
    function automatic logic [NLIGHT-1:0] mask_of(input logic [PW-1:0] p);
        return PHASE_MASK[(NPHASE-1-int'(p))*NLIGHT +: NLIGHT];
    endfunction

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NPHASE);
    endfunction

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]           cur_q, cur_d, sel;
    logic [NLIGHT-1:0][1:0]  light_q, light_d;
    logic                    busy_q, busy_d;
    logic [NPHASE-1:0]       demand;
    logic [NLIGHT-1:0]       cur_mask_d;
    logic                    own, other, any_dem, found;

    always_comb begin
        demand = '0;
        for (int p = 0; p < NPHASE; p++) begin
            demand[p] = |(sensor & mask_of(PW'(p)));
        end
        own     = demand[cur_q];
        other   = |(demand & ~(NPHASE'(1) << cur_q));
        any_dem = |demand;
    end

    // Search starts after the current phase; the current phase itself is checked last.
    always_comb begin
        sel   = cur_q;
        found = 1'b0;
        for (int i = 1; i <= NPHASE; i++) begin
            if (!found && demand[wrap(int'(cur_q) + i)]) begin
                sel   = wrap(int'(cur_q) + i);
                found = 1'b1;
            end
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (any_dem) begin
                    state_d = S_GREEN;
                    cur_d   = sel;
                    cnt_d   = '0;
                end
            end
            S_GREEN: begin
                if (other && ((int'(cnt_q) >= MIN_GREEN-1 && !own) ||
                              int'(cnt_q) >= MAX_GREEN-1)) begin
                    state_d = S_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_YELLOW: begin
                if (int'(cnt_q) >= YELLOW-1) begin
                    state_d = S_ALLRED;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (int'(cnt_q) >= ALL_RED-1) begin
                    cnt_d = '0;
                    if (any_dem) begin
                        state_d = S_GREEN;
                        cur_d   = sel;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Lights are computed from the next state so they switch on the same edge as the state.
    always_comb begin
        cur_mask_d = mask_of(cur_d);
        for (int l = 0; l < NLIGHT; l++) begin
            light_d[l] = C_RED;
            if (cur_mask_d[l]) begin
                if (state_d == S_GREEN) begin
                    light_d[l] = C_GRN;
                end else if (state_d == S_YELLOW) begin
                    light_d[l] = C_YEL;
                end
            end
        end
        busy_d = (state_d == S_GREEN) || (state_d == S_YELLOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ALLRED;
            cnt_q   <= '0;
            cur_q   <= PW'(NPHASE-1);
            light_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            light_q <= light_d;
            busy_q  <= busy_d;
        end
    end

    assign light        = light_q;
    assign active_phase = cur_q;
    assign phase_busy   = busy_q;

endmodule
